// File: rtl/gmm_mul_pipe.sv
// rtl/gmm_mul_pipe.sv - pipelined bubble-collapsing unsigned multiplier with valid/ready on both sides
// Each stage adds one B_W/STAGES-bit chunk of b's partial product into a running accumulator.
module gmm_mul_pipe #(
   parameter int A_W    = 17,
   parameter int B_W    = 16,
   parameter int STAGES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               snk_valid,
   input  logic [A_W-1:0]     snk_a,
   input  logic [B_W-1:0]     snk_b,
   output logic               snk_ready,
   input  logic               src_ready,
   output logic               src_valid,
   output logic [A_W+B_W-1:0] src_data
);

   localparam int C   = B_W / STAGES;
   localparam int P_W = A_W + B_W;

   logic [STAGES-1:0] v_q, v_d, ld;
   logic [A_W-1:0]    a_q   [STAGES];
   logic [A_W-1:0]    a_d   [STAGES];
   logic [B_W-1:0]    b_q   [STAGES];
   logic [B_W-1:0]    b_d   [STAGES];
   logic [P_W-1:0]    acc_q [STAGES];
   logic [P_W-1:0]    acc_d [STAGES];
   logic [P_W-1:0]    acc_in[STAGES];
   logic [P_W-1:0]    pp    [STAGES];

   // A stage may load when it or any stage after it is empty, or the sink drains the last one.
   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         logic room;
         room = src_ready;
         for (int j = i; j < STAGES; j++) begin
            room = room | ~v_q[j];
         end
         ld[i] = room;
      end
   end

   always_comb begin
      v_d[0]    = ld[0] ? snk_valid : v_q[0];
      a_d[0]    = snk_a;
      b_d[0]    = snk_b;
      acc_in[0] = '0;
      for (int i = 1; i < STAGES; i++) begin
         v_d[i]    = ld[i] ? v_q[i-1] : v_q[i];
         a_d[i]    = a_q[i-1];
         b_d[i]    = b_q[i-1];
         acc_in[i] = acc_q[i-1];
      end
      for (int i = 0; i < STAGES; i++) begin
         pp[i]    = P_W'(a_d[i]) * P_W'(b_d[i][i*C +: C]);
         acc_d[i] = acc_in[i] + (pp[i] << (i * C));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            acc_q[i] <= '0;
         end
      end else begin
         v_q <= v_d;
         for (int i = 0; i < STAGES; i++) begin
            if (ld[i]) begin
               a_q[i]   <= a_d[i];
               b_q[i]   <= b_d[i];
               acc_q[i] <= acc_d[i];
            end
         end
      end
   end

   assign snk_ready = ld[0];
   assign src_valid = v_q[STAGES-1];
   assign src_data  = acc_q[STAGES-1];

endmodule

// File: tb/tb_gmm_mul_pipe.sv
// tb/tb_gmm_mul_pipe.sv - self-checking bench for gmm_mul_pipe
// Scoreboard holds a*b for every accepted pair and is checked at each falling edge.
module tb_gmm_mul_pipe;

   logic        clk;
   logic        rst;
   logic        snk_valid;
   logic [16:0] snk_a;
   logic [15:0] snk_b;
   logic        snk_ready;
   logic        src_ready;
   logic        src_valid;
   logic [32:0] src_data;

   int          checks = 0;
   int          errors = 0;

   logic [63:0] q[$];
   logic        hold_q = 1'b0;
   logic [63:0] prev_data = '0;

   gmm_mul_pipe #(.A_W(17), .B_W(16), .STAGES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .snk_valid (snk_valid),
      .snk_a     (snk_a),
      .snk_b     (snk_b),
      .snk_ready (snk_ready),
      .src_ready (src_ready),
      .src_valid (src_valid),
      .src_data  (src_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: compares output first, then records the pair that transfers at the next edge.
   always @(negedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         hold_q = 1'b0;
      end else if (!clk) begin
         if (hold_q) begin
            chk("stall_valid", {63'd0, src_valid}, 64'd1);
            chk("stall_data", {31'd0, src_data}, prev_data);
         end
         if (src_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_spurious actual=%0h expected=none", src_data);
            end else begin
               chk("sb_data", {31'd0, src_data}, q[0]);
               if (src_ready) void'(q.pop_front());
            end
         end
         hold_q    = src_valid && !src_ready;
         prev_data = {31'd0, src_data};
         if (snk_valid && snk_ready) q.push_back(64'(snk_a) * 64'(snk_b));
      end
   end

   task automatic op_literal(input string name, input logic [16:0] a, input logic [15:0] b,
                             input logic [63:0] exp);
      logic seen;
      snk_valid = 1'b1; snk_a = a; snk_b = b;
      step();
      snk_valid = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (!seen && src_valid) begin
            chk(name, {31'd0, src_data}, exp);
            seen = 1'b1;
         end
         if (!seen) step();
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_valid expected=%0h", name, exp);
      end
      step();
   endtask

   initial begin
      int k;
      rst = 1'b0; snk_valid = 1'b0; snk_a = '0; snk_b = '0; src_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", {63'd0, src_valid}, 64'd0);
      chk("reset_data", {31'd0, src_data}, 64'd0);
      chk("reset_snk_ready", {63'd0, snk_ready}, 64'd1);
      rst = 1'b1;
      chk("release_snk_ready", {63'd0, snk_ready}, 64'd1);

      // single op: visible after the 4th edge counting the accept edge, for one cycle
      snk_valid = 1'b1; snk_a = 17'd3; snk_b = 16'd5;
      step();
      snk_valid = 1'b0;
      chk("single_e0", {63'd0, src_valid}, 64'd0);
      step(); chk("single_e1", {63'd0, src_valid}, 64'd0);
      step(); chk("single_e2", {63'd0, src_valid}, 64'd0);
      step();
      chk("single_valid", {63'd0, src_valid}, 64'd1);
      chk("single_data", {31'd0, src_data}, 64'd15);
      step(); chk("single_once", {63'd0, src_valid}, 64'd0);

      op_literal("ext_max", 17'h1FFFF, 16'hFFFF, 64'h1_FFFD_0001);
      op_literal("ext_zero", 17'h0, 16'hFFFF, 64'h0);
      op_literal("ext_msb", 17'h1, 16'h8000, 64'h8000);
      op_literal("ext_amsb", 17'h10000, 16'h0003, 64'h3_0000);

      // streaming: 16 back-to-back pairs, outputs valid after edges 3..18
      for (int c = 0; c < 20; c++) begin
         if (c < 16) begin
            snk_valid = 1'b1;
            snk_a = 17'($urandom);
            snk_b = 16'($urandom);
            chk("stream_snk_ready", {63'd0, snk_ready}, 64'd1);
         end else begin
            snk_valid = 1'b0;
         end
         step();
         chk("stream_valid", {63'd0, src_valid}, (c >= 3 && c <= 18) ? 64'd1 : 64'd0);
      end

      // backpressure: exactly 4 accepted before snk_ready drops
      src_ready = 1'b0;
      k = 0;
      snk_valid = 1'b1; snk_a = 17'd100; snk_b = 16'd200;
      for (int c = 0; c < 8; c++) begin
         chk("bp_snk_ready", {63'd0, snk_ready}, (k < 4) ? 64'd1 : 64'd0);
         if (snk_ready) k++;
         step();
         snk_a = 17'(100 + k); snk_b = 16'(200 + k);
      end
      snk_valid = 1'b0;
      src_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         chk("bp_drain_valid", {63'd0, src_valid}, 64'd1);
         chk("bp_drain_data", {31'd0, src_data}, 64'((100 + c) * (200 + c)));
         step();
      end
      chk("bp_empty", {63'd0, src_valid}, 64'd0);

      // bubble collapse: Y catches up behind a stalled X
      snk_valid = 1'b1; snk_a = 17'd11; snk_b = 16'd13;
      step();
      snk_valid = 1'b0;
      step(); step();
      src_ready = 1'b0;
      step();
      chk("bubble_x_valid", {63'd0, src_valid}, 64'd1);
      chk("bubble_x_data", {31'd0, src_data}, 64'd143);
      step();
      snk_valid = 1'b1; snk_a = 17'd17; snk_b = 16'd19;
      step();
      snk_valid = 1'b0;
      step(); step(); step();
      chk("bubble_x_held", {31'd0, src_data}, 64'd143);
      chk("bubble_snk_ready", {63'd0, snk_ready}, 64'd1);
      src_ready = 1'b1;
      step();
      chk("bubble_y_valid", {63'd0, src_valid}, 64'd1);
      chk("bubble_y_data", {31'd0, src_data}, 64'd323);
      step();
      chk("bubble_done", {63'd0, src_valid}, 64'd0);

      // reset mid-flight with an item at the output
      for (int c = 0; c < 3; c++) begin
         snk_valid = 1'b1; snk_a = 17'(c + 1); snk_b = 16'(c + 2);
         step();
      end
      snk_valid = 1'b0;
      step();
      chk("pre_rst_valid", {63'd0, src_valid}, 64'd1);
      #1 rst = 1'b0;
      #1;
      chk("rst_async_valid", {63'd0, src_valid}, 64'd0);
      chk("rst_async_data", {31'd0, src_data}, 64'd0);
      #1 rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("post_rst_idle", {63'd0, src_valid}, 64'd0);
      end
      snk_valid = 1'b1; snk_a = 17'd7; snk_b = 16'd9;
      step();
      snk_valid = 1'b0;
      step(); step();
      chk("post_rst_lat", {63'd0, src_valid}, 64'd0);
      step();
      chk("post_rst_valid", {63'd0, src_valid}, 64'd1);
      chk("post_rst_data", {31'd0, src_data}, 64'd63);
      step(); step();
      chk("sb_drained", 64'(q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
